branch_resolve_queue: RTL and testbench

- Back-end counterpart of the front-end predictor: holds the prediction metadata of every in-flight fetched instruction in program order.
- When execute resolves an instruction, compares the actual outcome against the stored prediction.
- Drives the predictor update bus (is_branch/is_jump/is_taken/is_miss, last PHT index, instruction PC, target) that feeds BP/GHR/PHT/BTB.
- On a misprediction, issues a one-cycle front-end redirect and drops every younger entry.

---
 rtl/branch_resolve_queue.sv | 163 ++++++++++++++++
 tb/tb_branch_resolve_queue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue.sv
// In-order queue of front-end predictions; resolves the head against execute results,
// drives the predictor update bus and issues a front-end redirect on mispredict.
module branch_resolve_queue #(
   parameter int DEPTH     = 8,
   parameter int GHR_WIDTH = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push_valid,
   output logic                       push_ready,
   input  logic [31:0]                push_pc,
   input  logic [GHR_WIDTH-1:0]       push_pht_index,
   input  logic                       push_pred_taken,
   input  logic [31:0]                push_pred_target,
   input  logic                       res_valid,
   output logic                       res_ready,
   input  logic                       res_is_branch,
   input  logic                       res_is_jump,
   input  logic                       res_taken,
   input  logic [31:0]                res_target,
   output logic                       upd_is_branch,
   output logic                       upd_is_jump,
   output logic                       upd_is_taken,
   output logic                       upd_is_miss,
   output logic [GHR_WIDTH-1:0]       upd_pht_index,
   output logic [31:0]                upd_inst_pc,
   output logic [31:0]                upd_target,
   output logic                       redirect_valid,
   output logic [31:0]                redirect_pc,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

   logic [31:0]          r_pc        [DEPTH];
   logic [GHR_WIDTH-1:0] r_pht       [DEPTH];
   logic                 r_pred_taken[DEPTH];
   logic [31:0]          r_pred_tgt  [DEPTH];

   logic [AW-1:0]        r_head;
   logic [AW-1:0]        r_tail;
   logic [AW:0]          r_count;

   logic                 r_upd_is_branch;
   logic                 r_upd_is_jump;
   logic                 r_upd_is_taken;
   logic                 r_upd_is_miss;
   logic [GHR_WIDTH-1:0] r_upd_pht_index;
   logic [31:0]          r_upd_inst_pc;
   logic [31:0]          r_upd_target;
   logic                 r_redirect_valid;
   logic [31:0]          r_redirect_pc;

   logic                 w_push;
   logic                 w_pop;
   logic                 w_miss;
   logic                 w_actual_taken;
   logic [31:0]          w_head_pc;
   logic                 w_head_pred_taken;
   logic [31:0]          w_head_pred_tgt;

   assign push_ready        = (r_count != L_FULL);
   assign res_ready         = (r_count != '0);
   assign w_push            = push_valid && push_ready;
   assign w_pop             = res_valid && res_ready;
   assign w_head_pc         = r_pc[r_head];
   assign w_head_pred_taken = r_pred_taken[r_head];
   assign w_head_pred_tgt   = r_pred_tgt[r_head];
   assign w_actual_taken    = (res_is_branch && res_taken) || res_is_jump;

   // A non-branch predicted taken is a BTB alias and always mispredicts.
   always_comb begin
      w_miss = 1'b0;
      if (res_is_branch)
         w_miss = (w_head_pred_taken != res_taken) ||
                  (res_taken && (w_head_pred_tgt != res_target));
      else if (res_is_jump)
         w_miss = !w_head_pred_taken || (w_head_pred_tgt != res_target);
      else
         w_miss = w_head_pred_taken;
   end

   // NOTE: payload storage has no reset; r_count alone decides which slots are valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc[r_tail]         <= push_pc;
         r_pht[r_tail]        <= push_pht_index;
         r_pred_taken[r_tail] <= push_pred_taken;
         r_pred_tgt[r_tail]   <= push_pred_target;
      end
   end

   // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_head           <= '0;
         r_tail           <= '0;
         r_count          <= '0;
         r_upd_is_branch  <= 1'b0;
         r_upd_is_jump    <= 1'b0;
         r_upd_is_taken   <= 1'b0;
         r_upd_is_miss    <= 1'b0;
         r_upd_pht_index  <= '0;
         r_upd_inst_pc    <= '0;
         r_upd_target     <= '0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
      end else begin
         r_upd_is_branch  <= 1'b0;
         r_upd_is_jump    <= 1'b0;
         r_upd_is_taken   <= 1'b0;
         r_upd_is_miss    <= 1'b0;
         r_upd_pht_index  <= '0;
         r_upd_inst_pc    <= '0;
         r_upd_target     <= '0;
         r_redirect_valid <= 1'b0;
         if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end else begin
            if (w_pop) begin
               r_upd_is_branch  <= res_is_branch;
               r_upd_is_jump    <= res_is_jump;
               r_upd_is_taken   <= res_taken || res_is_jump;
               r_upd_is_miss    <= w_miss;
               r_upd_pht_index  <= r_pht[r_head];
               r_upd_inst_pc    <= w_head_pc;
               r_upd_target     <= res_target;
               r_redirect_valid <= w_miss;
               // Not-taken restart skips the delay slot.
               r_redirect_pc    <= w_actual_taken ? res_target : w_head_pc + 32'd8;
            end
            if (w_pop && w_miss) begin
               r_head  <= r_tail;
               r_count <= '0;
            end else begin
               if (w_pop)  r_head <= r_head + 1'b1;
               if (w_push) r_tail <= r_tail + 1'b1;
               case ({w_push, w_pop})
                  2'b10:   r_count <= r_count + 1'b1;
                  2'b01:   r_count <= r_count - 1'b1;
                  default: r_count <= r_count;
               endcase
            end
         end
      end
   end

   assign upd_is_branch  = r_upd_is_branch;
   assign upd_is_jump    = r_upd_is_jump;
   assign upd_is_taken   = r_upd_is_taken;
   assign upd_is_miss    = r_upd_is_miss;
   assign upd_pht_index  = r_upd_pht_index;
   assign upd_inst_pc    = r_upd_inst_pc;
   assign upd_target     = r_upd_target;
   assign redirect_valid = r_redirect_valid;
   assign redirect_pc    = r_redirect_pc;
   assign count          = r_count;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: vector table plus fill/wrap and flush sequences.
module tb_branch_resolve_queue;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        push_valid = 1'b0;
   logic        push_ready;
   logic [31:0] push_pc = '0;
   logic [4:0]  push_pht_index = '0;
   logic        push_pred_taken = 1'b0;
   logic [31:0] push_pred_target = '0;
   logic        res_valid = 1'b0;
   logic        res_ready;
   logic        res_is_branch = 1'b0;
   logic        res_is_jump = 1'b0;
   logic        res_taken = 1'b0;
   logic [31:0] res_target = '0;
   logic        upd_is_branch, upd_is_jump, upd_is_taken, upd_is_miss;
   logic [4:0]  upd_pht_index;
   logic [31:0] upd_inst_pc, upd_target, redirect_pc;
   logic        redirect_valid;
   logic [3:0]  count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   branch_resolve_queue #(.DEPTH(8), .GHR_WIDTH(5)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .push_valid(push_valid), .push_ready(push_ready), .push_pc(push_pc),
      .push_pht_index(push_pht_index), .push_pred_taken(push_pred_taken),
      .push_pred_target(push_pred_target),
      .res_valid(res_valid), .res_ready(res_ready), .res_is_branch(res_is_branch),
      .res_is_jump(res_is_jump), .res_taken(res_taken), .res_target(res_target),
      .upd_is_branch(upd_is_branch), .upd_is_jump(upd_is_jump), .upd_is_taken(upd_is_taken),
      .upd_is_miss(upd_is_miss), .upd_pht_index(upd_pht_index), .upd_inst_pc(upd_inst_pc),
      .upd_target(upd_target), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .count(count)
   );

   typedef struct {
      logic        pv;   logic [31:0] ppc;  logic [4:0] pht;  logic pt;  logic [31:0] ptgt;
      logic        rv;   logic rb;  logic rj;  logic rt;  logic [31:0] rtgt;
      logic        eb;   logic ej;  logic et;  logic em;  logic [4:0] epht;
      logic [31:0] epc;  logic [31:0] etgt;  logic erv;  logic [31:0] erpc;  logic [3:0] ecnt;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic pv, input logic [31:0] ppc, input logic [4:0] pht,
                      input logic pt, input logic [31:0] ptgt,
                      input logic rv, input logic rb, input logic rj, input logic rt,
                      input logic [31:0] rtgt,
                      input logic eb, input logic ej, input logic et, input logic em,
                      input logic [4:0] epht, input logic [31:0] epc, input logic [31:0] etgt,
                      input logic erv, input logic [31:0] erpc, input logic [3:0] ecnt);
      vec_t v;
      v.pv = pv; v.ppc = ppc; v.pht = pht; v.pt = pt; v.ptgt = ptgt;
      v.rv = rv; v.rb = rb; v.rj = rj; v.rt = rt; v.rtgt = rtgt;
      v.eb = eb; v.ej = ej; v.et = et; v.em = em; v.epht = epht;
      v.epc = epc; v.etgt = etgt; v.erv = erv; v.erpc = erpc; v.ecnt = ecnt;
      tbl.push_back(v);
   endtask

   task automatic drive(input logic pv, input logic [31:0] ppc, input logic [4:0] pht,
                        input logic pt, input logic [31:0] ptgt,
                        input logic rv, input logic rb, input logic rj, input logic rt,
                        input logic [31:0] rtgt);
      push_valid = pv; push_pc = ppc; push_pht_index = pht;
      push_pred_taken = pt; push_pred_target = ptgt;
      res_valid = rv; res_is_branch = rb; res_is_jump = rj; res_taken = rt; res_target = rtgt;
   endtask

   // Drive inputs, take one edge, leave #1 settle before outputs are sampled.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      flush = 1'b0;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, " count"}, 32'(count), 0);
      check({tag, " push_ready"}, 32'(push_ready), 1);
      check({tag, " res_ready"}, 32'(res_ready), 0);
      check({tag, " upd_bits"}, 32'({upd_is_branch, upd_is_jump, upd_is_taken, upd_is_miss}), 0);
      check({tag, " upd_pht"}, 32'(upd_pht_index), 0);
      check({tag, " upd_pc"}, upd_inst_pc, 0);
      check({tag, " upd_target"}, upd_target, 0);
      check({tag, " redirect_valid"}, 32'(redirect_valid), 0);
      check({tag, " redirect_pc"}, redirect_pc, 0);
   endtask

   initial begin
      logic [31:0] sb[$];
      logic [31:0] exp_pc;

      // pv ppc pht pt ptgt | rv rb rj rt rtgt | eb ej et em epht epc etgt erv erpc ecnt
      add(1, 32'h100, 3, 0, 0,            0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0,                  1, 1, 0, 0, 32'h104,  1, 0, 0, 0, 3, 32'h100, 32'h104, 0, 0, 0);
      add(1, 32'h200, 5, 0, 0,            0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      add(1, 32'h204, 6, 0, 0,            0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
      add(1, 32'h208, 7, 0, 0,            0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
      add(0, 0, 0, 0, 0,                  1, 1, 0, 1, 32'h400,  1, 0, 1, 1, 5, 32'h200, 32'h400, 1, 32'h400, 0);
      add(0, 0, 0, 0, 0,                  0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0,                  1, 1, 0, 1, 32'h40,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, 32'h300, 9, 1, 32'h500,      0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0,                  1, 0, 0, 0, 0,        0, 0, 0, 1, 9, 32'h300, 0, 1, 32'h308, 0);
      add(1, 32'h600, 1, 1, 32'h700,      0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0,                  1, 0, 1, 0, 32'h700,  0, 1, 1, 0, 1, 32'h600, 32'h700, 0, 0, 0);
      add(1, 32'h610, 2, 1, 32'h800,      0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      add(1, 32'h999, 0, 0, 0,            1, 1, 0, 1, 32'h804,  1, 0, 1, 1, 2, 32'h610, 32'h804, 1, 32'h804, 0);
      add(1, 32'h620, 4, 0, 0,            0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0,                  1, 0, 1, 0, 32'h900,  0, 1, 1, 1, 4, 32'h620, 32'h900, 1, 32'h900, 0);
      add(1, 32'hFFFF_FFFC, 31, 1, 32'h10, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0,                  1, 0, 0, 0, 32'h10,   0, 0, 0, 1, 31, 32'hFFFF_FFFC, 32'h10, 1, 32'h4, 0);
      add(1, 32'h700, 8, 0, 0,            0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      add(1, 32'h704, 10, 0, 0,           1, 1, 0, 0, 0,        1, 0, 0, 0, 8, 32'h700, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0,                  1, 1, 0, 0, 0,        1, 0, 0, 0, 10, 32'h704, 0, 0, 0, 0);

      // Reset, then idle after release.
      idle_inputs();
      step(); step();
      check_quiet("reset");
      rst = 1'b1;
      step(); step(); step();
      check_quiet("idle");

      foreach (tbl[i]) begin
         drive(tbl[i].pv, tbl[i].ppc, tbl[i].pht, tbl[i].pt, tbl[i].ptgt,
               tbl[i].rv, tbl[i].rb, tbl[i].rj, tbl[i].rt, tbl[i].rtgt);
         step();
         check($sformatf("v%0d upd_is_branch", i), 32'(upd_is_branch), 32'(tbl[i].eb));
         check($sformatf("v%0d upd_is_jump", i), 32'(upd_is_jump), 32'(tbl[i].ej));
         check($sformatf("v%0d upd_is_taken", i), 32'(upd_is_taken), 32'(tbl[i].et));
         check($sformatf("v%0d upd_is_miss", i), 32'(upd_is_miss), 32'(tbl[i].em));
         check($sformatf("v%0d upd_pht_index", i), 32'(upd_pht_index), 32'(tbl[i].epht));
         check($sformatf("v%0d upd_inst_pc", i), upd_inst_pc, tbl[i].epc);
         check($sformatf("v%0d upd_target", i), upd_target, tbl[i].etgt);
         check($sformatf("v%0d redirect_valid", i), 32'(redirect_valid), 32'(tbl[i].erv));
         if (tbl[i].erv)
            check($sformatf("v%0d redirect_pc", i), redirect_pc, tbl[i].erpc);
         check($sformatf("v%0d count", i), 32'(count), 32'(tbl[i].ecnt));
      end

      // Fill to DEPTH, then push+pop on full: the push must be dropped.
      for (int k = 0; k < 8; k++) begin
         drive(1, 32'h1000 + 32'(4*k), 5'(k), 0, 0, 0, 0, 0, 0, 0);
         sb.push_back(32'h1000 + 32'(4*k));
         step();
      end
      check("full count", 32'(count), 8);
      check("full push_ready", 32'(push_ready), 0);
      check("full res_ready", 32'(res_ready), 1);
      drive(1, 32'hBAD, 0, 0, 0, 1, 1, 0, 0, 0);
      exp_pc = sb.pop_front();
      step();
      check("full pop pc", upd_inst_pc, exp_pc);
      check("full pop count", 32'(count), 7);
      check("full pop push_ready", 32'(push_ready), 1);

      // Steady push+pop across the pointer wrap, then drain; order must follow the scoreboard.
      for (int k = 0; k < 10; k++) begin
         drive(1, 32'h2000 + 32'(4*k), 5'(k), 0, 0, 1, 1, 0, 0, 0);
         exp_pc = sb.pop_front();
         sb.push_back(32'h2000 + 32'(4*k));
         step();
         check($sformatf("wrap%0d pc", k), upd_inst_pc, exp_pc);
         check($sformatf("wrap%0d count", k), 32'(count), 7);
         check($sformatf("wrap%0d miss", k), 32'(upd_is_miss), 0);
      end
      for (int k = 0; k < 7; k++) begin
         drive(0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
         exp_pc = sb.pop_front();
         step();
         check($sformatf("drain%0d pc", k), upd_inst_pc, exp_pc);
         check($sformatf("drain%0d count", k), 32'(count), 32'(6 - k));
      end

      // Flush beats a mispredicting pop and a concurrent push.
      drive(1, 32'h3000, 1, 0, 0, 0, 0, 0, 0, 0); step();
      drive(1, 32'h3004, 2, 0, 0, 0, 0, 0, 0, 0); step();
      check("preflush count", 32'(count), 2);
      drive(1, 32'h3008, 3, 0, 0, 1, 1, 0, 1, 32'h40);
      flush = 1'b1;
      step();
      idle_inputs();
      check("flush count", 32'(count), 0);
      check("flush redirect_valid", 32'(redirect_valid), 0);
      check("flush upd_is_miss", 32'(upd_is_miss), 0);
      check("flush upd_is_branch", 32'(upd_is_branch), 0);
      step();
      check("postflush redirect_valid", 32'(redirect_valid), 0);
      check("postflush count", 32'(count), 0);
      drive(1, 32'hA00, 12, 0, 0, 0, 0, 0, 0, 0); step();
      drive(0, 0, 0, 0, 0, 1, 1, 0, 0, 32'h0); step();
      idle_inputs();
      check("postflush pop pc", upd_inst_pc, 32'hA00);
      check("postflush pop pht", 32'(upd_pht_index), 12);
      check("postflush pop count", 32'(count), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
